// File: rtl/nexys4_ddr.sv
// Nexys4-DDR top: UART debug master (udm) drives LED/SW registers and a byte-stream hash.
// Define TESTMEM_EN to map a TESTMEM_WORDS x 32 RAM at 0x8xxxxxxx; otherwise that region is unmapped.

// udm frames: 0x55 sync, then command byte.
//   0x00 check (replies 0x55), 0x80/0xC0 assert/release hreset,
//   0x81 write (addr LE, data LE), 0x82 read (addr LE, replies 4 data bytes LE).
module udm #(
  parameter int BAUD_DIV = 868
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx,
  output logic        tx,
  output logic        rst_o,
  output logic        req,
  output logic        we,
  output logic [31:0] addr,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  input  logic        ack,
  input  logic        resp,
  input  logic [31:0] rdata
);
  localparam logic [15:0] BIT_LAST = 16'(BAUD_DIV - 1);
  localparam logic [15:0] BIT_HALF = 16'(BAUD_DIV / 2 - 1);

  typedef enum logic [2:0] {S_SYNC, S_CMD, S_ADDR, S_DATA, S_BUS, S_WAIT, S_TX} state_t;
  state_t state_q, state_d;

  logic        rx_s1, rx_s, rx_busy, rx_vld;
  logic [15:0] rx_cnt, tx_cnt;
  logic [3:0]  rx_bit, tx_bit;
  logic [7:0]  rx_byte, tx_byte;
  logic        tx_busy, tx_start;
  logic [9:0]  tx_sh;
  logic [1:0]  cnt_q;
  logic        we_q, hreset_q;
  logic [31:0] addr_q, wdata_q, txbuf_q;
  logic [2:0]  txn_q;

  // RX: sample near mid-bit; a start bit that does not hold is treated as a glitch
  always_ff @(posedge clk) begin
    rx_s1  <= rx;
    rx_s   <= rx_s1;
    rx_vld <= 1'b0;
    if (!rst_n) begin
      rx_s1   <= 1'b1;
      rx_s    <= 1'b1;
      rx_busy <= 1'b0;
      rx_cnt  <= '0;
      rx_bit  <= '0;
    end else if (!rx_busy) begin
      if (!rx_s) begin
        rx_busy <= 1'b1;
        rx_cnt  <= BIT_HALF;
        rx_bit  <= '0;
      end
    end else if (rx_cnt != 16'd0) begin
      rx_cnt <= rx_cnt - 16'd1;
    end else begin
      rx_cnt <= BIT_LAST;
      rx_bit <= rx_bit + 4'd1;
      if (rx_bit == 4'd0) begin
        if (rx_s) rx_busy <= 1'b0;
      end else if (rx_bit <= 4'd8) begin
        rx_byte <= {rx_s, rx_byte[7:1]};
      end else begin
        rx_busy <= 1'b0;
        rx_vld  <= rx_s;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx_busy <= 1'b0;
      tx_sh   <= '1;
      tx_cnt  <= '0;
      tx_bit  <= '0;
    end else if (!tx_busy) begin
      if (tx_start) begin
        tx_busy <= 1'b1;
        tx_sh   <= {1'b1, tx_byte, 1'b0};
        tx_cnt  <= BIT_LAST;
        tx_bit  <= '0;
      end
    end else if (tx_cnt != 16'd0) begin
      tx_cnt <= tx_cnt - 16'd1;
    end else begin
      tx_cnt <= BIT_LAST;
      tx_sh  <= {1'b1, tx_sh[9:1]};
      tx_bit <= tx_bit + 4'd1;
      if (tx_bit == 4'd9) tx_busy <= 1'b0;
    end
  end

  always_comb begin
    state_d  = state_q;
    req      = 1'b0;
    tx_start = 1'b0;
    tx_byte  = txbuf_q[7:0];
    case (state_q)
      S_SYNC: if (rx_vld && rx_byte == 8'h55) state_d = S_CMD;
      S_CMD: if (rx_vld) begin
        case (rx_byte)
          8'h00:        state_d = S_TX;
          8'h81, 8'h82: state_d = S_ADDR;
          default:      state_d = S_SYNC;
        endcase
      end
      S_ADDR: if (rx_vld && cnt_q == 2'd3) state_d = we_q ? S_DATA : S_BUS;
      S_DATA: if (rx_vld && cnt_q == 2'd3) state_d = S_BUS;
      S_BUS: begin
        req = 1'b1;
        if (ack) state_d = we_q ? S_SYNC : S_WAIT;
      end
      S_WAIT: if (resp) state_d = S_TX;
      S_TX: if (!tx_busy) begin
        tx_start = 1'b1;
        if (txn_q == 3'd1) state_d = S_SYNC;
      end
      default: state_d = S_SYNC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_SYNC;
      hreset_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == S_CMD && rx_vld && rx_byte == 8'h80) hreset_q <= 1'b1;
      if (state_q == S_CMD && rx_vld && rx_byte == 8'hC0) hreset_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    case (state_q)
      S_CMD: if (rx_vld) begin
        we_q    <= (rx_byte == 8'h81);
        cnt_q   <= '0;
        txbuf_q <= 32'h55;
        txn_q   <= 3'd1;
      end
      S_ADDR: if (rx_vld) begin
        addr_q <= {rx_byte, addr_q[31:8]};
        cnt_q  <= cnt_q + 2'd1;
      end
      S_DATA: if (rx_vld) begin
        wdata_q <= {rx_byte, wdata_q[31:8]};
        cnt_q   <= cnt_q + 2'd1;
      end
      S_WAIT: if (resp) begin
        txbuf_q <= rdata;
        txn_q   <= 3'd4;
      end
      S_TX: if (!tx_busy) begin
        txbuf_q <= txbuf_q >> 8;
        txn_q   <= txn_q - 3'd1;
      end
      default: ;
    endcase
  end

  assign tx    = tx_sh[0];
  assign rst_o = hreset_q;
  assign we    = we_q;
  assign addr  = addr_q;
  assign be    = 4'hF;
  assign wdata = wdata_q;
endmodule

module nexys4_ddr #(
  parameter string SIM           = "NO",
  parameter int    UDM_BAUD_DIV  = 868,
  parameter int    TESTMEM_WORDS = 256
) (
  input  logic        CLK100MHZ,
  input  logic        CPU_RESETN,
  input  logic [15:0] SW,
  output logic [15:0] LED,
  input  logic        UART_TXD_IN,
  output logic        UART_RXD_OUT
);
  localparam logic [9:0] STRETCH_LAST = (SIM == "YES") ? 10'd15 : 10'd1023;

  logic        stretch_q, udm_rst, srst;
  logic [9:0]  stretch_cnt;
  logic        bus_req, bus_we, bus_ack;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_be, region;
  logic        wr, rd, done;
  logic [15:0] led_q, sw_s1, sw_s2;
  logic [31:0] len_q, n_q;
  logic [4:0]  rp_q;
  logic [7:0]  h_q [32];
  logic [7:0]  h_cur;
  logic        resp_p1;
  logic [31:0] rdata_p1;
  logic        unused_bits;

  always_ff @(posedge CLK100MHZ) begin
    if (!CPU_RESETN) begin
      stretch_q   <= 1'b1;
      stretch_cnt <= '0;
    end else if (stretch_q) begin
      stretch_cnt <= stretch_cnt + 10'd1;
      if (stretch_cnt == STRETCH_LAST) stretch_q <= 1'b0;
    end
  end
  assign srst = stretch_q | udm_rst;

  // The debug master survives its own hreset so the host keeps the link
  udm #(.BAUD_DIV(UDM_BAUD_DIV)) udm (
    .clk(CLK100MHZ), .rst_n(CPU_RESETN), .rx(UART_TXD_IN), .tx(UART_RXD_OUT),
    .rst_o(udm_rst), .req(bus_req), .we(bus_we), .addr(bus_addr), .be(bus_be),
    .wdata(bus_wdata), .ack(bus_ack), .resp(resp_p1), .rdata(bus_rdata)
  );

  assign bus_ack = bus_req;
  assign wr      = bus_req & bus_we;
  assign rd      = bus_req & ~bus_we;
  assign region  = bus_addr[31:28];
  assign done    = (n_q == len_q) && (len_q != 32'd0);
  assign h_cur   = h_q[n_q[4:0]];

  always_ff @(posedge CLK100MHZ) begin
    sw_s1 <= SW;
    sw_s2 <= sw_s1;
  end

  always_ff @(posedge CLK100MHZ) begin
    if (srst) begin
      led_q <= '0;
      len_q <= '0;
      n_q   <= '0;
      rp_q  <= '0;
      for (int i = 0; i < 32; i++) h_q[i] <= '0;
    end else begin
      if (wr) begin
        case (region)
          4'h0: if (!bus_addr[2]) led_q <= bus_wdata[15:0];
          4'h1: begin
            len_q <= bus_wdata;
            n_q   <= '0;
            rp_q  <= '0;
            for (int i = 0; i < 32; i++) h_q[i] <= '0;
          end
          4'h2: if (n_q < len_q) begin
            h_q[n_q[4:0]] <= {h_cur[6:0], h_cur[7]} ^ bus_wdata[7:0] ^ n_q[7:0];
            n_q           <= n_q + 32'd1;
          end
          default: ;
        endcase
      end
      if (rd && region == 4'h3) rp_q <= rp_q + 5'd1;
    end
  end

  // Read data stage: resp follows the read ack by one cycle
  always_ff @(posedge CLK100MHZ) begin
    if (!CPU_RESETN) resp_p1 <= 1'b0;
    else             resp_p1 <= rd;
    rdata_p1 <= '0;
    if (rd) begin
      case (region)
        4'h0: rdata_p1 <= bus_addr[2] ? {16'h0, sw_s2} : {16'h0, led_q};
        4'h1: rdata_p1 <= {done, 15'h0, n_q[15:0]};
        4'h3: rdata_p1 <= {24'h0, h_q[rp_q]};
        default: ;
      endcase
    end
  end

`ifdef TESTMEM_EN
  localparam int MAW = (TESTMEM_WORDS > 1) ? $clog2(TESTMEM_WORDS) : 1;
  logic [31:0]    mem [TESTMEM_WORDS];
  logic [31:0]    mem_rd_p1;
  logic           mem_sel_p1;
  logic [MAW-1:0] mem_idx;

  assign mem_idx = MAW'(bus_addr[9:2]);

  always_ff @(posedge CLK100MHZ) begin
    if (wr && region == 4'h8)
      for (int b = 0; b < 4; b++)
        if (bus_be[b]) mem[mem_idx][8*b +: 8] <= bus_wdata[8*b +: 8];
    mem_rd_p1  <= mem[mem_idx];
    mem_sel_p1 <= rd && region == 4'h8;
  end
  assign bus_rdata = mem_sel_p1 ? mem_rd_p1 : rdata_p1;
`else
  assign bus_rdata = rdata_p1;
`endif

  assign LED         = led_q;
  assign unused_bits = ^{bus_addr[27:0], bus_be};
endmodule

// File: tb/tb_nexys4_ddr.sv
// Bench for nexys4_ddr: drives the udm UART link, checks registers and the hash against a model.
module tb_nexys4_ddr;
  localparam int DIV = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] sw = 16'h0;
  logic [15:0] led;
  logic        txd_in = 1'b1;
  logic        rxd_out;
  int          tests = 0;
  int          fails = 0;
  logic [7:0]  msg[$];
  logic [7:0]  ref_h[32];

  nexys4_ddr #(.SIM("YES"), .UDM_BAUD_DIV(DIV), .TESTMEM_WORDS(256)) dut (
    .CLK100MHZ(clk), .CPU_RESETN(rst_n), .SW(sw), .LED(led),
    .UART_TXD_IN(txd_in), .UART_RXD_OUT(rxd_out)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", tests, fails);
    $fatal(1, "watchdog");
  end

  task automatic send_byte(input logic [7:0] b);
    logic [9:0] f;
    f = {1'b1, b, 1'b0};
    @(posedge clk); #1;
    for (int i = 0; i < 10; i++) begin
      txd_in = f[i];
      repeat (DIV) @(posedge clk);
      #1;
    end
  endtask

  task automatic recv_byte(output logic [7:0] b, output bit ok);
    int t;
    ok = 0;
    b = '0;
    t = 0;
    while (!ok && t < 3000) begin
      @(negedge clk);
      if (rxd_out == 1'b0) ok = 1;
      t++;
    end
    if (ok) begin
      repeat (DIV / 2) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
        repeat (DIV) @(negedge clk);
        b[i] = rxd_out;
      end
      repeat (DIV) @(negedge clk);
      if (rxd_out !== 1'b1) ok = 0;
    end
  endtask

  task automatic udm_write(input logic [31:0] a, input logic [31:0] d);
    send_byte(8'h55);
    send_byte(8'h81);
    for (int i = 0; i < 4; i++) send_byte(a[8*i +: 8]);
    for (int i = 0; i < 4; i++) send_byte(d[8*i +: 8]);
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic udm_read(input logic [31:0] a, output logic [31:0] d, output bit ok);
    logic [7:0] b;
    bit k;
    send_byte(8'h55);
    send_byte(8'h82);
    for (int i = 0; i < 4; i++) send_byte(a[8*i +: 8]);
    ok = 1;
    d = '0;
    for (int i = 0; i < 4; i++) begin
      recv_byte(b, k);
      if (!k) ok = 0;
      d[8*i +: 8] = b;
    end
  endtask

  // Digest from the absorption rule: byte i folds into slot i mod 32 after a 1-bit rotate
  task automatic model_hash(input int len);
    int slot;
    for (int i = 0; i < 32; i++) ref_h[i] = 8'h00;
    for (int i = 0; i < msg.size() && i < len; i++) begin
      slot = i % 32;
      ref_h[slot] = {ref_h[slot][6:0], ref_h[slot][7]} ^ msg[i] ^ 8'(i);
    end
  endtask

  task automatic test_reset;
    int cyc;
    logic [31:0] d;
    bit ok;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    tests++; if (dut.srst !== 1'b1) begin fails++; $display("FAIL reset_srst_high: got %b want 1", dut.srst); end
    tests++; if (led !== 16'h0) begin fails++; $display("FAIL reset_led: got %h want 0000", led); end
    tests++; if (rxd_out !== 1'b1) begin fails++; $display("FAIL reset_uart_idle: got %b want 1", rxd_out); end
    rst_n = 1'b1;
    cyc = 0;
    while (dut.srst === 1'b1 && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    tests++; if (cyc != 16) begin fails++; $display("FAIL reset_stretch: got %0d cycles want 16", cyc); end
    udm_read(32'h1000_0000, d, ok);
    tests++; if (!ok || d !== 32'h0) begin fails++; $display("FAIL reset_status: got %h ok=%0d want 00000000", d, ok); end
  endtask

  task automatic test_udm_check;
    logic [7:0] b;
    logic [31:0] d;
    bit ok;
    send_byte(8'h55);
    send_byte(8'h00);
    recv_byte(b, ok);
    tests++; if (!ok || b !== 8'h55) begin fails++; $display("FAIL udm_check_id: got %h ok=%0d want 55", b, ok); end
    udm_write(32'h0000_0000, 32'h0000_1234);
    udm_write(32'h1000_0000, 32'd7);
    udm_write(32'h2000_0000, 32'h77);
    tests++; if (led !== 16'h1234) begin fails++; $display("FAIL pre_hreset_led: got %h want 1234", led); end
    send_byte(8'h55);
    send_byte(8'h80);
    repeat (4) @(posedge clk);
    #1;
    tests++; if (dut.srst !== 1'b1) begin fails++; $display("FAIL hreset_srst: got %b want 1", dut.srst); end
    tests++; if (led !== 16'h0) begin fails++; $display("FAIL hreset_led: got %h want 0000", led); end
    send_byte(8'h55);
    send_byte(8'hC0);
    repeat (4) @(posedge clk);
    #1;
    tests++; if (dut.srst !== 1'b0) begin fails++; $display("FAIL hreset_release: got %b want 0", dut.srst); end
    udm_read(32'h1000_0000, d, ok);
    tests++; if (!ok || d !== 32'h0) begin fails++; $display("FAIL hreset_status: got %h ok=%0d want 00000000", d, ok); end
    udm_read(32'h3000_0000, d, ok);
    tests++; if (!ok || d !== 32'h0) begin fails++; $display("FAIL hreset_digest: got %h ok=%0d want 00000000", d, ok); end
  endtask

  task automatic test_led_sw;
    logic [31:0] d;
    logic [15:0] r;
    bit ok;
    udm_write(32'h0000_0000, 32'h5A5A_5A5A);
    tests++; if (led !== 16'h5A5A) begin fails++; $display("FAIL led_write: got %h want 5a5a", led); end
    udm_read(32'h0000_0000, d, ok);
    tests++; if (!ok || d !== 32'h0000_5A5A) begin fails++; $display("FAIL led_read: got %h ok=%0d want 00005a5a", d, ok); end
    sw = 16'h0030;
    udm_read(32'h0000_0004, d, ok);
    tests++; if (!ok || d !== 32'h0000_0030) begin fails++; $display("FAIL sw_read: got %h ok=%0d want 00000030", d, ok); end
    r = 16'($urandom);
    sw = r;
    udm_read(32'h0000_0004, d, ok);
    tests++; if (!ok || d !== {16'h0, r}) begin fails++; $display("FAIL sw_rand: got %h ok=%0d want %h", d, ok, {16'h0, r}); end
    udm_read(32'h5000_0000, d, ok);
    tests++; if (!ok || d !== 32'h0) begin fails++; $display("FAIL unmapped_read: got %h ok=%0d want 00000000", d, ok); end
  endtask

  task automatic test_hash_hello;
    logic [7:0] hello [5];
    logic [7:0] want [5];
    logic [31:0] d;
    bit ok;
    hello = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F};
    want  = '{8'h48, 8'h64, 8'h6E, 8'h6F, 8'h6B};
    udm_write(32'h1000_0000, 32'd5);
    for (int i = 0; i < 5; i++) udm_write(32'h2000_0000, {24'h0, hello[i]});
    for (int i = 0; i < 32; i++) begin
      udm_read(32'h3000_0000, d, ok);
      tests++;
      if (!ok || d !== {24'h0, (i < 5) ? want[i] : 8'h00}) begin
        fails++; $display("FAIL hello_digest[%0d]: got %h ok=%0d want %h", i, d, ok, (i < 5) ? want[i] : 8'h00);
      end
    end
    udm_read(32'h1000_0000, d, ok);
    tests++; if (!ok || d !== 32'h8000_0005) begin fails++; $display("FAIL hello_status: got %h ok=%0d want 80000005", d, ok); end
  endtask

  task automatic test_hash_hello_world;
    string s;
    logic [31:0] d;
    logic [31:0] rd11;
    bit ok;
    s = "Hello World!";
    msg.delete();
    for (int i = 0; i < s.len(); i++) msg.push_back(s[i]);
    model_hash(12);
    udm_write(32'h1000_0000, 32'd12);
    foreach (msg[i]) udm_write(32'h2000_0000, {24'h0, msg[i]});
    rd11 = '0;
    for (int i = 0; i < 33; i++) begin
      udm_read(32'h3000_0000, d, ok);
      if (i == 11) rd11 = d;
      tests++;
      if (!ok || d !== {24'h0, ref_h[i % 32]}) begin
        fails++; $display("FAIL hw_digest[%0d]: got %h ok=%0d want %h", i, d, ok, ref_h[i % 32]);
      end
    end
    tests++; if (rd11 !== 32'h2A) begin fails++; $display("FAIL hw_byte11: got %h want 0000002a", rd11); end
    udm_read(32'h1000_0000, d, ok);
    tests++; if (!ok || d !== 32'h8000_000C) begin fails++; $display("FAIL hw_status: got %h ok=%0d want 8000000c", d, ok); end
  endtask

  task automatic test_overrun;
    logic [31:0] d;
    bit ok;
    msg.delete();
    for (int i = 0; i < 3; i++) msg.push_back(8'($urandom));
    model_hash(2);
    udm_write(32'h1000_0000, 32'd2);
    foreach (msg[i]) udm_write(32'h2000_0000, {24'h0, msg[i]});
    udm_read(32'h1000_0000, d, ok);
    tests++; if (!ok || d !== 32'h8000_0002) begin fails++; $display("FAIL overrun_status: got %h ok=%0d want 80000002", d, ok); end
    for (int i = 0; i < 3; i++) begin
      udm_read(32'h3000_0000, d, ok);
      tests++;
      if (!ok || d !== {24'h0, ref_h[i]}) begin
        fails++; $display("FAIL overrun_digest[%0d]: got %h ok=%0d want %h", i, d, ok, ref_h[i]);
      end
    end
  endtask

  task automatic test_random_message;
    int len, half;
    logic [31:0] d;
    bit ok;
    len = $urandom_range(33, 36);
    half = $urandom_range(1, 20);
    msg.delete();
    for (int i = 0; i < len; i++) msg.push_back(8'($urandom));
    model_hash(len);
    udm_write(32'h1000_0000, len);
    for (int i = 0; i < half; i++) udm_write(32'h2000_0000, {24'($urandom) , msg[i]});
    udm_read(32'h1000_0000, d, ok);
    tests++; if (!ok || d !== 32'(half)) begin fails++; $display("FAIL rand_mid_status: got %h ok=%0d want %h", d, ok, 32'(half)); end
    for (int i = half; i < len; i++) udm_write(32'h2000_0000, {24'h0, msg[i]});
    for (int i = 0; i < 32; i++) begin
      udm_read(32'h3000_0000, d, ok);
      tests++;
      if (!ok || d !== {24'h0, ref_h[i]}) begin
        fails++; $display("FAIL rand_digest[%0d]: got %h ok=%0d want %h (len %0d)", i, d, ok, ref_h[i], len);
      end
    end
    udm_read(32'h1000_0000, d, ok);
    tests++; if (!ok || d !== {1'b1, 15'h0, 16'(len)}) begin fails++; $display("FAIL rand_status: got %h ok=%0d want %h", d, ok, {1'b1, 15'h0, 16'(len)}); end
  endtask

  task automatic test_testmem;
    logic [31:0] d, w2, e1, e2;
    bit ok;
    w2 = $urandom;
`ifdef TESTMEM_EN
    e1 = 32'hDEAD_BEEF;
    e2 = w2;
`else
    e1 = 32'h0;
    e2 = 32'h0;
`endif
    udm_write(32'h8000_0024, 32'hDEAD_BEEF);
    udm_write(32'h8000_0028, w2);
    udm_read(32'h8000_0024, d, ok);
    tests++; if (!ok || d !== e1) begin fails++; $display("FAIL testmem_0x24: got %h ok=%0d want %h", d, ok, e1); end
    udm_read(32'h8000_0028, d, ok);
    tests++; if (!ok || d !== e2) begin fails++; $display("FAIL testmem_0x28: got %h ok=%0d want %h", d, ok, e2); end
  endtask

  initial begin
    test_reset;
    test_udm_check;
    test_led_sw;
    test_hash_hello;
    test_hash_hello_world;
    test_overrun;
    test_random_message;
    test_testmem;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/nexys4_ddr.md
Name: nexys4_ddr

Overview:
FPGA top for the Nexys4-DDR board. A UART debug master (codebase `udm` core, instance name `udm`) drives an internal 32-bit bus.
- The bus reaches an LED register, a switch input register, an optional test memory and a byte-stream hash accelerator.
- A host writes a message length, then streams message bytes, then reads back a 32-byte digest one byte per read.

Parameters:
SIM, "NO", "YES" shortens the reset-stretch counter to 16 cycles; "NO" uses 1024 cycles.
UDM_BAUD_DIV, 868, clock cycles per UART bit at 115200 baud with a 100 MHz clock.
TESTMEM_WORDS, 256, depth of the optional test memory in 32-bit words.

Ports:
CLK100MHZ  in  1  100 MHz system clock; the only clock.
CPU_RESETN  in  1  synchronous active-low reset.
SW  in  16  board switches.
LED  out  16  board LEDs.
UART_TXD_IN  in  1  UART serial input (host to FPGA); idles high.
UART_RXD_OUT  out  1  UART serial output (FPGA to host); idles high.

Behaviour:
- Reset generation:
  - CPU_RESETN is sampled on CLK100MHZ; low asserts internal `srst` immediately.
  - After release, `srst` stays high for the stretch count (16 or 1024 cycles per SIM), then drops.
  - `srst` is also asserted while the udm core's reset output is high (host hreset command).
- udm core:
  - UART is 8N1, divider UDM_BAUD_DIV.
  - Master bus signals: req, we, addr[31:0], be[3:0], wdata[31:0], ack, resp, rdata[31:0].
- Bus timing:
  - Every request is acked in the same cycle it is presented.
  - Read data is returned with resp one cycle after the read ack.
  - Unmapped reads return 0; unmapped writes are ignored and still acked.
  - Address decode uses addr[31:28]; all registers are word-wide and be is ignored.
- 0x00000000 LED register:
  - Read/write; LED = reg[15:0].
  - Reset value 0.
- 0x00000004 SW register:
  - Read-only; returns {16'h0, SW}.
  - SW is passed through a 2-flop synchronizer.
- 0x1xxxxxxx hash length/status:
  - Write: len <= wdata; clears all 32 digest bytes H[0..31] to 0, clears byte counter n and read pointer rp.
  - Read: {done, 15'h0, n[15:0]}, where done = (n == len) and len != 0.
- 0x2xxxxxxx hash data:
  - Write with n < len: b = wdata[7:0]; H[n mod 32] <= rotl8(H[n mod 32],1) ^ b ^ n[7:0]; n <= n+1.
  - Writes with n >= len are ignored.
  - One byte is absorbed per cycle; no backpressure.
- 0x3xxxxxxx digest read:
  - Returns {24'h0, H[rp]}, then rp <= rp+1, wrapping 31 to 0.
  - Reading is allowed before done and returns the current state.
  - A length write in the same cycle as a digest read is impossible (single master).
- 0x8xxxxxxx test memory: see Optional Feature.
- Reset values: len=0, n=0, rp=0, all H=0, LED=0, UART_RXD_OUT=1.
- An `srst` pulse in the middle of a message discards the message; the host must rewrite the length.
- Width rules:
  - n is 32-bit and compared against the full len.
  - rotl8 is an 8-bit rotate left by 1.

Optional Feature:
TESTMEM_EN:
- Defined: 0x8xxxxxxx maps to a TESTMEM_WORDS x 32 RAM.
  - Word index is addr[9:2], wrapping at depth.
  - Byte enables are honoured on writes.
  - Reads return data with resp one cycle after ack.
  - RAM contents are not reset.
- Undefined: the region behaves as unmapped (reads 0, writes ignored).

Test Plan:
- Reset: hold CPU_RESETN low for 3 cycles with SIM="YES" -> srst high, then low 16 cycles after release; LED=0; UART_RXD_OUT=1.
- udm check/hreset at 115200 -> idcode response received; srst pulses; hash state and LED cleared.
- LED/SW: write 0x5A5A5A5A to 0x0 -> LED=0x5A5A. Set SW=0x0030, read 0x4 -> 0x00000030.
- Hash "Hello":
  - Write 5 to 0x10000000, then bytes 0x48,0x65,0x6C,0x6C,0x6F to 0x20000000.
  - 32 reads of 0x30000000 -> 0x48,0x64,0x6E,0x6F,0x6B, then 27 x 0x00.
  - Status read -> 0x80000005.
- Hash "Hello World!" (len 12), written after a previous message:
  - First read -> 0x48 (state cleared by the length write).
  - Byte 11 ('!') -> H[11] = 0x21 ^ 0x0B = 0x2A.
  - Read 33 -> wraps to H[0].
- Overrun: len=2, write 3 bytes -> third byte ignored; n=2; done=1.
- TESTMEM_EN defined: write 0xDEADBEEF to 0x80000024, read back -> 0xDEADBEEF. Undefined: the same read returns 0.
